// File: rtl/sprite_pkg.sv
// Shared constants, entry type and helpers for the sprite sorter slice.
// Distance is Q8.8 signed fixed point; screen column is passed through untouched.
package sprite_pkg;

  localparam int SPRITE_SLOTS  = 8;
  localparam int SPRITE_IDX_W  = 3;
  localparam int SPRITE_SCOL_W = 11;
  localparam int SPRITE_DIST_W = 16;
  localparam int SPRITE_CNT_W  = SPRITE_IDX_W + 1;

  localparam logic [SPRITE_CNT_W-1:0] CNT_ONE  = SPRITE_CNT_W'(1);
  localparam logic [SPRITE_IDX_W-1:0] IDX_ONE  = SPRITE_IDX_W'(1);
  localparam logic [SPRITE_CNT_W-1:0] CNT_LAST = SPRITE_CNT_W'(SPRITE_SLOTS);

  typedef struct packed {
    logic [SPRITE_DIST_W-1:0] sdist;
    logic [SPRITE_SCOL_W-1:0] scol;
    logic [SPRITE_IDX_W-1:0]  index;
  } sprite_entry_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EMIT  = 2'd2
  } sorter_state_t;

  function automatic logic dist_positive(input logic [SPRITE_DIST_W-1:0] d);
    return !d[SPRITE_DIST_W-1] && (d != '0);
  endfunction

  function automatic logic dist_ge(input logic [SPRITE_DIST_W-1:0] a,
                                   input logic [SPRITE_DIST_W-1:0] b);
    return $signed(a) >= $signed(b);
  endfunction

endpackage

// File: rtl/sprite_sorted_list.sv
// Registered list of sprite entries kept in descending signed distance order.
// Supports clear, single-cycle insert by parallel compare/shift, and pop from the head.
module sprite_sorted_list
  import sprite_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic                     insert,
  input  logic                     pop,
  input  logic [SPRITE_DIST_W-1:0] new_sdist,
  input  logic [SPRITE_SCOL_W-1:0] new_scol,
  input  logic [SPRITE_IDX_W-1:0]  new_index,
  output logic [SPRITE_DIST_W-1:0] head_sdist,
  output logic [SPRITE_SCOL_W-1:0] head_scol,
  output logic [SPRITE_IDX_W-1:0]  head_index,
  output logic [SPRITE_CNT_W-1:0]  len
);

  sprite_entry_t           ents [SPRITE_SLOTS];
  sprite_entry_t           ins  [SPRITE_SLOTS];
  sprite_entry_t           new_ent;
  logic [SPRITE_SLOTS-1:0] keep;

  assign new_ent = '{sdist: new_sdist, scol: new_scol, index: new_index};

  // Entries with distance >= the newcomer stay put, so equal distances keep fetch order.
  always_comb begin
    for (int i = 0; i < SPRITE_SLOTS; i++)
      keep[i] = (SPRITE_CNT_W'(i) < len) && dist_ge(ents[i].sdist, new_sdist);
    ins[0] = keep[0] ? ents[0] : new_ent;
    for (int i = 1; i < SPRITE_SLOTS; i++) begin
      if (keep[i])
        ins[i] = ents[i];
      else if (keep[i-1])
        ins[i] = new_ent;
      else
        ins[i] = ents[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      for (int i = 0; i < SPRITE_SLOTS; i++)
        ents[i] <= '0;
      len <= '0;
    end else if (insert) begin
      for (int i = 0; i < SPRITE_SLOTS; i++)
        ents[i] <= ins[i];
      len <= len + CNT_ONE;
    end else if (pop && (len != '0)) begin
      for (int i = 0; i < SPRITE_SLOTS - 1; i++)
        ents[i] <= ents[i+1];
      ents[SPRITE_SLOTS-1] <= '0;
      len <= len - CNT_ONE;
    end
  end

  assign head_sdist = ents[0].sdist;
  assign head_scol  = ents[0].scol;
  assign head_index = ents[0].index;

endmodule

// File: rtl/sprite_sorter.sv
// Scans the sprite buffer on start, keeps sprites in front of the camera and streams
// them farthest-first to the renderer over valid/ready.
//
//  state   | meaning
//  S_IDLE  | waiting for start; buffer disabled
//  S_FETCH | N_SLOTS address cycles plus one drain cycle; sampled entries inserted
//  S_EMIT  | presenting list head until the last entry is accepted
module sprite_sorter
  import sprite_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [SPRITE_CNT_W-1:0]  count,
  output logic                     buf_oe,
  output logic                     buf_we,
  output logic [SPRITE_IDX_W-1:0]  buf_index,
  input  logic [SPRITE_DIST_W-1:0] buf_sdist,
  input  logic [SPRITE_SCOL_W-1:0] buf_scol,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SPRITE_DIST_W-1:0] out_sdist,
  output logic [SPRITE_SCOL_W-1:0] out_scol,
  output logic [SPRITE_IDX_W-1:0]  out_index,
  output logic                     out_last
);

  sorter_state_t            state;
  logic [SPRITE_CNT_W-1:0]  k;
  logic [SPRITE_CNT_W-1:0]  k_next;
  logic [SPRITE_CNT_W-1:0]  count_next;
  logic [SPRITE_CNT_W-1:0]  len;
  logic [SPRITE_IDX_W-1:0]  slot;
  logic                     accept;
  logic                     sample_ok;
  logic                     pop;
  logic [SPRITE_DIST_W-1:0] head_sdist;
  logic [SPRITE_SCOL_W-1:0] head_scol;
  logic [SPRITE_IDX_W-1:0]  head_index;

  // The buffer registers its read data, so fetch cycle k carries slot k-1.
  assign k_next     = k + CNT_ONE;
  assign slot       = k[SPRITE_IDX_W-1:0] - IDX_ONE;
  assign accept     = (state == S_IDLE) && start && !done;
  assign sample_ok  = (state == S_FETCH) && (k != '0) && dist_positive(buf_sdist);
  assign count_next = sample_ok ? count + CNT_ONE : count;
  assign pop        = out_valid && out_ready;
  assign buf_we     = 1'b0;

  sprite_sorted_list u_list (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (accept),
    .insert     (sample_ok),
    .pop        (pop),
    .new_sdist  (buf_sdist),
    .new_scol   (buf_scol),
    .new_index  (slot),
    .head_sdist (head_sdist),
    .head_scol  (head_scol),
    .head_index (head_index),
    .len        (len)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      k         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      count     <= '0;
      buf_oe    <= 1'b0;
      buf_index <= '0;
      out_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            state     <= S_FETCH;
            k         <= '0;
            busy      <= 1'b1;
            count     <= '0;
            buf_oe    <= 1'b1;
            buf_index <= '0;
          end
        end
        S_FETCH: begin
          k     <= k_next;
          count <= count_next;
          if (k_next < CNT_LAST) begin
            buf_oe    <= 1'b1;
            buf_index <= k_next[SPRITE_IDX_W-1:0];
          end else begin
            buf_oe    <= 1'b0;
            buf_index <= '0;
          end
          if (k == CNT_LAST) begin
            k <= '0;
            if (count_next == '0) begin
              state <= S_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state     <= S_EMIT;
              out_valid <= 1'b1;
            end
          end
        end
        S_EMIT: begin
          if (out_ready && (len == CNT_ONE)) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign out_sdist = out_valid ? head_sdist : '0;
  assign out_scol  = out_valid ? head_scol  : '0;
  assign out_index = out_valid ? head_index : '0;
  assign out_last  = out_valid && (len == CNT_ONE);

endmodule

// File: tb/tb_sprite_sorter.sv
// Scoreboard bench for sprite_sorter: a registered buffer model feeds the scan and a
// reference sort of the buffer contents predicts the renderer stream.
module tb_sprite_sorter;
  import sprite_pkg::*;

  logic                     clk = 1'b0;
  logic                     reset_n = 1'b0;
  logic                     start = 1'b0;
  logic                     busy, done, buf_oe, buf_we, out_valid, out_last;
  logic                     out_ready = 1'b0;
  logic [SPRITE_CNT_W-1:0]  count;
  logic [SPRITE_IDX_W-1:0]  buf_index, out_index;
  logic [SPRITE_DIST_W-1:0] buf_sdist = '0;
  logic [SPRITE_SCOL_W-1:0] buf_scol = '0;
  logic [SPRITE_DIST_W-1:0] out_sdist;
  logic [SPRITE_SCOL_W-1:0] out_scol;

  typedef struct {
    logic [SPRITE_DIST_W-1:0] sdist;
    logic [SPRITE_SCOL_W-1:0] scol;
    logic [SPRITE_IDX_W-1:0]  idx;
    logic                     last;
  } exp_t;

  logic [SPRITE_DIST_W-1:0] mem_sdist [SPRITE_SLOTS];
  logic [SPRITE_SCOL_W-1:0] mem_scol  [SPRITE_SLOTS];
  exp_t                     exp_q [$];
  logic [SPRITE_IDX_W-1:0]  idx_log [$];

  int total = 0, bad = 0;
  int cyc = 0, start_cyc = 0, rel;
  int done_cnt = 0, done_rel = -1, first_valid_rel = -1, exp_count = 0;
  int ready_mode = 0, ph = 0;
  bit mon_on = 1'b0;
  logic prev_valid = 1'b0, prev_ready = 1'b0;
  logic [30:0] prev_bus = '0;

  sprite_sorter dut (
    .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done), .count(count),
    .buf_oe(buf_oe), .buf_we(buf_we), .buf_index(buf_index), .buf_sdist(buf_sdist),
    .buf_scol(buf_scol), .out_valid(out_valid), .out_ready(out_ready), .out_sdist(out_sdist),
    .out_scol(out_scol), .out_index(out_index), .out_last(out_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Sprite buffer: read data registered, one cycle behind the address.
  always @(posedge clk)
    if (buf_oe) begin
      buf_sdist <= mem_sdist[buf_index];
      buf_scol  <= mem_scol[buf_index];
    end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      ph++;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (ph % 3 == 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  always @(negedge clk) begin
    exp_t e;
    logic [30:0] bus;
    if (mon_on) begin
      rel = cyc - start_cyc;
      bus = {out_sdist, out_scol, out_index, out_last};
      check_val("buf_we", buf_we, 0);
      if (buf_oe) idx_log.push_back(buf_index);
      if (done) begin
        done_cnt++;
        done_rel = rel;
      end
      if (out_valid) begin
        if (first_valid_rel < 0) first_valid_rel = rel;
        if (prev_valid && !prev_ready) check_val("stall_hold", bus, prev_bus);
        if (out_ready) begin
          if (exp_q.size() == 0) check_val("unexpected_out", 1, 0);
          else begin
            e = exp_q.pop_front();
            check_val("out_index", out_index, e.idx);
            check_val("out_sdist", out_sdist, e.sdist);
            check_val("out_scol", out_scol, e.scol);
            check_val("out_last", out_last, e.last);
          end
        end
      end else begin
        check_val("idle_zero", bus, 0);
      end
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_bus   = bus;
    end
  end

  // Reference order: repeatedly pick the largest positive distance, lowest slot on ties.
  task automatic push_expected();
    bit   used [SPRITE_SLOTS];
    int   best;
    exp_t e;
    exp_q.delete();
    for (int i = 0; i < SPRITE_SLOTS; i++) used[i] = 1'b0;
    exp_count = 0;
    for (int i = 0; i < SPRITE_SLOTS; i++)
      if ($signed(mem_sdist[i]) > 0) exp_count++;
    for (int n = 0; n < exp_count; n++) begin
      best = -1;
      for (int i = 0; i < SPRITE_SLOTS; i++)
        if (!used[i] && $signed(mem_sdist[i]) > 0 &&
            (best < 0 || $signed(mem_sdist[i]) > $signed(mem_sdist[best])))
          best = i;
      used[best] = 1'b1;
      e.sdist = mem_sdist[best];
      e.scol  = mem_scol[best];
      e.idx   = SPRITE_IDX_W'(best);
      e.last  = (n == exp_count - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic begin_scan();
    done_cnt = 0;
    done_rel = -1;
    first_valid_rel = -1;
    idx_log.delete();
    push_expected();
    @(posedge clk); #1;
    start = 1'b1;
    start_cyc = cyc;
  endtask

  task automatic run_scan(input string name, input int mode, input bit extra);
    int c;
    ready_mode = mode;
    begin_scan();
    c = 0;
    while (done_cnt == 0 && c < 200) begin
      @(posedge clk); #1;
      c++;
      start = extra && (c == 4 || c == 11 || c == 15);
    end
    start = 1'b0;
    if (done_cnt == 0) check_val({name, "_timeout"}, 0, 1);
    repeat (3) @(posedge clk);
    #1;
    check_val({name, "_count"}, count, exp_count);
    check_val({name, "_single_done"}, done_cnt, 1);
    check_val({name, "_busy_after"}, busy, 0);
    check_val({name, "_queue_left"}, exp_q.size(), 0);
    check_val({name, "_idx_seq_len"}, idx_log.size(), SPRITE_SLOTS);
    for (int i = 0; i < idx_log.size() && i < SPRITE_SLOTS; i++)
      check_val({name, "_idx_seq"}, idx_log[i], i);
    if (exp_count == 0) begin
      check_val({name, "_no_valid"}, first_valid_rel, -1);
      check_val({name, "_done_cycle"}, done_rel, 10);
    end else begin
      check_val({name, "_first_valid"}, first_valid_rel, 10);
      if (mode == 0) check_val({name, "_done_cycle"}, done_rel, 10 + exp_count);
    end
  endtask

  task automatic abort_scan(input string name, input int at_rel, input int mode);
    int c;
    ready_mode = mode;
    begin_scan();
    c = 0;
    while (c < at_rel) begin
      @(posedge clk); #1;
      c++;
      start = 1'b0;
    end
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check_val({name, "_busy"}, busy, 0);
    check_val({name, "_buf_oe"}, buf_oe, 0);
    check_val({name, "_buf_index"}, buf_index, 0);
    check_val({name, "_valid"}, out_valid, 0);
    check_val({name, "_count"}, count, 0);
    check_val({name, "_done"}, done, 0);
    done_cnt = 0;
    repeat (14) @(posedge clk);
    #1;
    check_val({name, "_no_done"}, done_cnt, 0);
  endtask

  task automatic load_scol();
    for (int i = 0; i < SPRITE_SLOTS; i++) mem_scol[i] = SPRITE_SCOL_W'(i * 301 + 17);
  endtask

  initial begin
    load_scol();
    mem_sdist = '{default: '0};
    repeat (3) @(posedge clk);
    #1;
    mon_on = 1'b1;
    @(negedge clk);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_count", count, 0);
    check_val("rst_buf_oe", buf_oe, 0);
    check_val("rst_valid", out_valid, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    mem_sdist = '{16'd5, 16'd0, 16'd9, 16'hFFFE, 16'd9, 16'd1, 16'd0, 16'd3};
    run_scan("basic", 0, 1'b0);

    mem_sdist = '{default: '0};
    run_scan("empty", 0, 1'b0);

    mem_sdist = '{16'd5, 16'd0, 16'd9, 16'hFFFE, 16'd9, 16'd1, 16'd0, 16'd3};
    run_scan("stall", 1, 1'b0);
    run_scan("restart", 0, 1'b1);

    abort_scan("rst_fetch", 5, 0);
    abort_scan("rst_emit", 12, 2);
    run_scan("after_rst", 0, 1'b0);

    mem_sdist = '{16'd0, 16'h0100, 16'hFFFB, 16'h0100, 16'h8000, 16'd0, 16'h0100, 16'hFFFF};
    run_scan("ties", 0, 1'b0);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < SPRITE_SLOTS; i++)
        mem_sdist[i] = SPRITE_DIST_W'($urandom_range(0, 7)) - SPRITE_DIST_W'(3);
      run_scan("random", 1, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
